// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive path.
// Used by the receiver FSM and the letter lookup table.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam int         MAX_ELEMS      = 4;
    localparam logic [4:0] LETTER_INVALID = 5'd31;
    localparam logic       DOT            = 1'b0;
    localparam logic       DASH           = 1'b1;

endpackage

// File: rtl/morse_letter_lut.sv
// Combinational Morse pattern to A-Z index table.
// Element 0 sits in bit 0; 1 = dash. Unmapped patterns give 31.
module morse_letter_lut
    import morse_pkg::*;
(
    input  logic [2:0] sym_len,
    input  logic [3:0] sym_bits,
    output logic [4:0] letter
);

    logic [3:0] masked;

    // Drop bits beyond the element count before matching
    always_comb begin
        masked = 4'd0;
        case (sym_len)
            3'd1:    masked = {3'b000, sym_bits[0]};
            3'd2:    masked = {2'b00, sym_bits[1:0]};
            3'd3:    masked = {1'b0, sym_bits[2:0]};
            3'd4:    masked = sym_bits;
            default: masked = 4'd0;
        endcase
    end

    // International alphabet, keyed on length and pattern
    always_comb begin
        letter = LETTER_INVALID;
        case ({sym_len, masked})
            {3'd1, 4'd0}:  letter = 5'd4;
            {3'd1, 4'd1}:  letter = 5'd19;
            {3'd2, 4'd2}:  letter = 5'd0;
            {3'd2, 4'd0}:  letter = 5'd8;
            {3'd2, 4'd3}:  letter = 5'd12;
            {3'd2, 4'd1}:  letter = 5'd13;
            {3'd3, 4'd1}:  letter = 5'd3;
            {3'd3, 4'd3}:  letter = 5'd6;
            {3'd3, 4'd5}:  letter = 5'd10;
            {3'd3, 4'd7}:  letter = 5'd14;
            {3'd3, 4'd2}:  letter = 5'd17;
            {3'd3, 4'd0}:  letter = 5'd18;
            {3'd3, 4'd4}:  letter = 5'd20;
            {3'd3, 4'd6}:  letter = 5'd22;
            {3'd4, 4'd1}:  letter = 5'd1;
            {3'd4, 4'd5}:  letter = 5'd2;
            {3'd4, 4'd4}:  letter = 5'd5;
            {3'd4, 4'd0}:  letter = 5'd7;
            {3'd4, 4'd14}: letter = 5'd9;
            {3'd4, 4'd2}:  letter = 5'd11;
            {3'd4, 4'd6}:  letter = 5'd15;
            {3'd4, 4'd11}: letter = 5'd16;
            {3'd4, 4'd8}:  letter = 5'd21;
            {3'd4, 4'd9}:  letter = 5'd23;
            {3'd4, 4'd13}: letter = 5'd24;
            {3'd4, 4'd3}:  letter = 5'd25;
            default:       letter = LETTER_INVALID;
        endcase
    end

endmodule

// File: rtl/morse_receiver.sv
// Morse receiver: times marks/spaces on tick, assembles elements,
// and emits a decoded letter as a one-cycle valid pulse.
module morse_receiver
    import morse_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int DOT_MAX    = 2,
    parameter int LETTER_GAP = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_in,
    output logic       letter_valid,
    output logic [4:0] letter,
    output logic [2:0] sym_len,
    output logic [3:0] sym_bits,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP     = CNT_W'(LETTER_GAP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       bits_q, bits_d;
    logic [2:0]       ecnt_q, ecnt_d;
    logic             ovf_q, ovf_d;
    logic             elem;
    logic [4:0]       lut_letter;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign elem    = (32'(cnt_q) > DOT_MAX) ? DASH : DOT;

    morse_letter_lut u_lut (
        .sym_len  (ecnt_q),
        .sym_bits (bits_q),
        .letter   (lut_letter)
    );

    // Next-state, duration counter and element accumulator
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        ecnt_d  = ecnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (tick && key_in) begin
                    state_d = MARK;
                    cnt_d   = CNT_ONE;
                end
            end
            MARK: begin
                if (tick) begin
                    if (key_in) begin
                        cnt_d = cnt_inc;
                    end else begin
                        if (ecnt_q < 3'(MAX_ELEMS)) begin
                            bits_d[ecnt_q[1:0]] = elem;
                            ecnt_d = ecnt_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        state_d = SPACE;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            SPACE: begin
                if (tick) begin
                    if (key_in) begin
                        state_d = MARK;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == GAP) begin
                            state_d = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                bits_d  = 4'd0;
                ecnt_d  = 3'd0;
                ovf_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
                if (tick && key_in) begin
                    state_d = MARK;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bits_d  = 4'd0;
                ecnt_d  = 3'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // FSM state and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= 4'd0;
            ecnt_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            ecnt_q  <= ecnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output registers load on entry to EMIT and hold afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            letter_valid <= 1'b0;
            letter       <= LETTER_INVALID;
            sym_len      <= 3'd0;
            sym_bits     <= 4'd0;
            err          <= 1'b0;
        end else begin
            letter_valid <= (state_d == EMIT);
            if (state_d == EMIT) begin
                letter   <= lut_letter;
                sym_len  <= ecnt_q;
                sym_bits <= bits_q;
                err      <= ovf_q || (lut_letter == LETTER_INVALID);
            end
        end
    end

endmodule

// File: tb/tb_morse_receiver.sv
// Testbench for morse_receiver: string-based Morse model
// checked every cycle, plus literal per-letter expectations.
module tb_morse_receiver;

    localparam int DOT_MAX    = 2;
    localparam int LETTER_GAP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       key_in;
    logic       letter_valid;
    logic [4:0] letter;
    logic [2:0] sym_len;
    logic [3:0] sym_bits;
    logic       err;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p_base = 0;

    morse_receiver #(
        .CNT_W      (4),
        .DOT_MAX    (DOT_MAX),
        .LETTER_GAP (LETTER_GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .key_in       (key_in),
        .letter_valid (letter_valid),
        .letter       (letter),
        .sym_len      (sym_len),
        .sym_bits     (sym_bits),
        .err          (err)
    );

    always #5 clk = ~clk;

    string tab [26] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
        "-.--", "--.."
    };

    int         mark_run = 0;
    int         space_run = 0;
    bit         ovf_m = 0;
    string      pat = "";
    logic       exp_valid = 1'b0;
    logic [4:0] exp_letter = 5'd31;
    logic [2:0] exp_len = 3'd0;
    logic [3:0] exp_bits = 4'd0;
    logic       exp_err = 1'b0;

    // Model outputs after the next edge, from inputs stable now
    task automatic model_step();
        string c;
        int idx;
        if (reset) begin
            mark_run = 0; space_run = 0; pat = ""; ovf_m = 0;
            exp_valid = 0; exp_letter = 5'd31; exp_len = 0;
            exp_bits = 0; exp_err = 0;
            return;
        end
        exp_valid = 0;
        if (!tick) return;
        if (key_in) begin
            mark_run++;
            space_run = 0;
        end else if (mark_run > 0) begin
            c = (mark_run > DOT_MAX) ? "-" : ".";
            if (pat.len() < 4) pat = {pat, c};
            else ovf_m = 1;
            mark_run = 0;
            space_run = 1;
        end else if (pat.len() > 0) begin
            space_run++;
            if (space_run == LETTER_GAP) begin
                idx = 31;
                for (int i = 0; i < 26; i++)
                    if (tab[i] == pat) idx = i;
                exp_letter = 5'(idx);
                exp_len = 3'(pat.len());
                exp_bits = 4'd0;
                for (int i = 0; i < pat.len(); i++)
                    exp_bits[i] = (pat[i] == 8'h2D);
                exp_err = ovf_m || (idx == 31);
                exp_valid = 1;
                pat = ""; ovf_m = 0; space_run = 0;
            end
        end
    endtask

    // Every-cycle compare against the model, then advance it
    always @(negedge clk) begin
        checks++;
        if ({letter_valid, letter, sym_len, sym_bits, err} !==
            {exp_valid, exp_letter, exp_len, exp_bits, exp_err}) begin
            errors++;
            $display("FAIL cycle t=%0t got v=%b l=%0d n=%0d b=%b e=%b want v=%b l=%0d n=%0d b=%b e=%b",
                     $time, letter_valid, letter, sym_len, sym_bits, err,
                     exp_valid, exp_letter, exp_len, exp_bits, exp_err);
        end
        if (letter_valid === 1'b1) pulses++;
        model_step();
    end

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic send(input bit k, input int n, input int per, input bit glitch);
        for (int i = 0; i < n; i++) begin
            key_in = k;
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
            for (int j = 1; j < per; j++) begin
                if (glitch) key_in = ~key_in;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic expect_letter(input string name, input int np, input int l,
                                 input int n, input int b, input int e);
        repeat (4) @(posedge clk);
        #1;
        check({name, " pulses"}, pulses - p_base, np);
        check({name, " letter"}, int'(letter), l);
        check({name, " len"}, int'(sym_len), n);
        check({name, " bits"}, int'(sym_bits), b);
        check({name, " err"}, int'(err), e);
        p_base = pulses;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", int'(letter_valid), 0);
        check("reset letter", int'(letter), 31);
        check("reset len", int'(sym_len), 0);
        check("reset bits", int'(sym_bits), 0);
        reset = 1'b0;
        p_base = pulses;

        send(0, 10, 2, 0);
        expect_letter("idle", 0, 31, 0, 0, 0);

        send(1, 1, 4, 0); send(0, 3, 4, 0);
        expect_letter("E", 1, 4, 1, 4'b0000, 0);

        send(1, 1, 4, 0); send(0, 1, 4, 0);
        send(1, 3, 4, 0); send(0, 3, 4, 0);
        expect_letter("A", 1, 0, 2, 4'b0010, 0);
        send(1, 5, 4, 0); send(0, 3, 4, 0);
        expect_letter("T", 1, 19, 1, 4'b0001, 0);

        for (int i = 0; i < 5; i++) begin
            send(1, 1, 4, 0); send(0, 1, 4, 0);
        end
        send(0, 3, 4, 0);
        expect_letter("ovf", 1, 7, 4, 4'b0000, 1);

        for (int i = 0; i < 4; i++) begin
            send(1, 3, 4, 0); send(0, 1, 4, 0);
        end
        send(0, 2, 4, 0);
        expect_letter("inval", 1, 31, 4, 4'b1111, 1);

        send(1, 1, 4, 1); send(0, 2, 4, 1);
        send(1, 1, 4, 1); send(0, 3, 4, 1);
        expect_letter("I", 1, 8, 2, 4'b0000, 0);

        send(1, 20, 2, 0); send(0, 3, 2, 0);
        expect_letter("sat", 1, 19, 1, 4'b0001, 0);

        send(1, 1, 1, 0); send(0, 3, 1, 0);
        send(1, 2, 1, 0); send(0, 3, 1, 0);
        expect_letter("b2b", 2, 4, 1, 4'b0000, 0);

        send(1, 2, 4, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst valid", int'(letter_valid), 0);
        check("rst err", int'(err), 0);
        send(0, 5, 4, 0);
        expect_letter("rstmid", 0, 31, 0, 0, 0);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
